// File: rtl/gray_counter_pkg.sv
// Shared constants and Gray-code helper functions for the gray_counter block.
package gray_counter_pkg;

  localparam int unsigned GRAY_W_DEFAULT = 4;

  // Binary to reflected Gray code; callers zero-extend narrower values.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB downwards.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Companion interface for gray_counter: a driver view for rst and a monitor view
// that samples the binary count and its Gray-code twin.
interface gray_counter_if
  import gray_counter_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input logic clk
);

  logic             rst;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] gray;

  // Drives the active-low reset in step with clk.
  clocking drv_cb @(posedge clk);
    output rst;
  endclocking

  // Samples both counter outputs on the rising edge.
  clocking mon_cb @(posedge clk);
    input count;
    input gray;
  endclocking

  modport drv (clocking drv_cb);
  modport mon (clocking mon_cb);

endinterface

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray encoder of configurable width.
module gray_encode
  import gray_counter_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // Zero-extend into the 32-bit helper, keep the low WIDTH bits.
  assign gray_o = WIDTH'(bin2gray(32'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// Free-running binary counter with a registered Gray-code output.
// Both outputs come straight from flops; next Gray is encoded from next count,
// so the two ports always describe the same value with no relative latency.
// Optional macro GRAY_COUNTER_ASSERT_EN compiles in concurrent checks.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] o_o,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;

  // Next count, wrapping naturally modulo 2^WIDTH.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
  end

  gray_encode #(
    .WIDTH (WIDTH)
  ) u_gray_encode (
    .bin_i  (cnt_d),
    .gray_o (gray_d)
  );

  // Count and Gray registers; async clear holds both at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      gray_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
    end
  end

  assign o_o  = cnt_q;
  assign gray = gray_q;

`ifdef GRAY_COUNTER_ASSERT_EN
  logic chk_vld_q;

  // Marks that a full counting edge has occurred since the last reset, so
  // history-based checks never compare against pre-reset samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_vld_q <= 1'b0;
    end else begin
      chk_vld_q <= 1'b1;
    end
  end

  a_gray_match: assert property (@(posedge clk) disable iff (!rst)
    gray_q == WIDTH'(bin2gray(32'(cnt_q))));

  a_gray_one_bit: assert property (@(posedge clk) disable iff (!rst)
    chk_vld_q |-> ($countones(gray_q ^ $past(gray_q)) == 1));

  a_count_inc: assert property (@(posedge clk) disable iff (!rst)
    chk_vld_q |-> (cnt_q == WIDTH'($past(cnt_q) + WIDTH'(1))));
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed, table-driven bench for gray_counter at WIDTH=4.
module tb_gray_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] o_o;
  logic [W-1:0] gray;

  int n_pass;
  int n_total;

  typedef struct {
    logic         rst;
    logic [W-1:0] exp_o;
    logic [W-1:0] exp_gray;
  } vec_t;

  vec_t vecs[22];

  gray_counter #(
    .WIDTH (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .o_o  (o_o),
    .gray (gray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] tb_gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] prev_gray;
    logic [W-1:0] model;
    logic         prev_rst;
    bit           found;

    n_pass  = 0;
    n_total = 0;

    // Three reset edges, then release: counts 1..15, wrap to 0, then 1.
    vecs[0] = '{1'b0, 4'd0, 4'b0000};
    vecs[1] = '{1'b0, 4'd0, 4'b0000};
    vecs[2] = '{1'b0, 4'd0, 4'b0000};
    vecs[3]  = '{1'b1, 4'd1,  4'b0001};
    vecs[4]  = '{1'b1, 4'd2,  4'b0011};
    vecs[5]  = '{1'b1, 4'd3,  4'b0010};
    vecs[6]  = '{1'b1, 4'd4,  4'b0110};
    vecs[7]  = '{1'b1, 4'd5,  4'b0111};
    vecs[8]  = '{1'b1, 4'd6,  4'b0101};
    vecs[9]  = '{1'b1, 4'd7,  4'b0100};
    vecs[10] = '{1'b1, 4'd8,  4'b1100};
    vecs[11] = '{1'b1, 4'd9,  4'b1101};
    vecs[12] = '{1'b1, 4'd10, 4'b1111};
    vecs[13] = '{1'b1, 4'd11, 4'b1110};
    vecs[14] = '{1'b1, 4'd12, 4'b1010};
    vecs[15] = '{1'b1, 4'd13, 4'b1011};
    vecs[16] = '{1'b1, 4'd14, 4'b1001};
    vecs[17] = '{1'b1, 4'd15, 4'b1000};
    vecs[18] = '{1'b1, 4'd0,  4'b0000};
    vecs[19] = '{1'b1, 4'd1,  4'b0001};
    vecs[20] = '{1'b1, 4'd2,  4'b0011};
    vecs[21] = '{1'b1, 4'd3,  4'b0010};

    // Assert reset before the first clock edge and check the async clear.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_o", 32'(o_o), 32'd0);
    check("async_reset_gray", 32'(gray), 32'd0);

    prev_gray = '0;
    prev_rst  = 1'b0;
    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst;
      tick();
      check($sformatf("vec%0d_o", i), 32'(o_o), 32'(vecs[i].exp_o));
      check($sformatf("vec%0d_gray", i), 32'(gray), 32'(vecs[i].exp_gray));
      if (vecs[i].rst) begin
        check($sformatf("vec%0d_onebit", i), 32'($countones(gray ^ prev_gray)), 32'd1);
      end
      prev_gray = gray;
      prev_rst  = vecs[i].rst;
    end

    // Advance to a count of 9, bounded.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_o == 4'd9) found = 1'b1;
      else tick();
    end
    check("reach_nine", 32'(found), 32'd1);

    // Reset pulse entirely inside one clock period clears outputs immediately.
    #3;
    rst = 1'b0;
    #1;
    check("midpulse_o", 32'(o_o), 32'd0);
    check("midpulse_gray", 32'(gray), 32'd0);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("resume%0d_o", k), 32'(o_o), 32'(k));
    end
    check("resume3_gray", 32'(gray), 32'b0010);

    // Free-running scoreboard over 120 edges.
    model     = o_o;
    prev_gray = gray;
    for (int c = 0; c < 120; c++) begin
      tick();
      model = model + W'(1);
      check("sb_count", 32'(o_o), 32'(model));
      check("sb_gray2bin", 32'(tb_gray2bin(gray)), 32'(o_o));
      check("sb_onebit", 32'($countones(gray ^ prev_gray)), 32'd1);
      prev_gray = gray;
    end

    // Reset held across edges keeps outputs at zero.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("hold_async_o", 32'(o_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("hold_o", 32'(o_o), 32'd0);
      check("hold_gray", 32'(gray), 32'd0);
    end
    rst = 1'b1;
    tick();
    check("release_o", 32'(o_o), 32'd1);
    check("release_gray", 32'(gray), 32'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: o_o  output  WIDTH  registered binary count.
REQ-005 Port: gray  output  WIDTH  registered Gray-code equivalent of o_o.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.

Function
REQ-007 While rst is high, o_o SHALL increment by 1 on every rising clk edge; there is no enable.
REQ-008 gray SHALL equal o_o XOR (o_o >> 1) in every cycle.
- Both registers update on the same edge, so there is zero relative latency.
REQ-009 gray SHALL be a flop output with no combinational path from o_o to the port.
- Next gray is computed from next o_o.
REQ-010 Arithmetic SHALL be modulo 2^WIDTH.
- o_o = 2^WIDTH-1 wraps to 0.
- gray = 1 followed by zeros (4'b1000 for WIDTH=4) wraps to all zeros.
REQ-011 Exactly one bit of gray SHALL change per clock edge, including across the wrap.
REQ-012 The first edge after rst deasserts SHALL produce o_o=1, gray=1.
- rst is deasserted synchronously to clk by the environment.

Reset
REQ-013 rst low SHALL force o_o=0 and gray=0 immediately, independent of clk.
REQ-014 Outputs SHALL hold 0 for as long as rst is low; clock edges during reset are ignored.
REQ-015 Reset asserted mid-count SHALL clear both outputs at once.
- Counting restarts from 0 after release; there is no residual state.

Configuration
REQ-016 Macro GRAY_COUNTER_ASSERT_EN SHALL compile in concurrent assertions, all disabled while rst is low:
- gray == o_o ^ (o_o >> 1);
- $countones(gray ^ $past(gray)) == 1;
- o_o == $past(o_o) + 1, modulo 2^WIDTH.
REQ-017 Without GRAY_COUNTER_ASSERT_EN, the RTL SHALL contain no assertion code.
- Functional behaviour is identical with or without the macro.

Structure
REQ-018 Package gray_counter_pkg SHALL hold:
- the default-width constant GRAY_W_DEFAULT = 4;
- function bin2gray(bin) returning bin ^ (bin >> 1);
- function gray2bin(gray), a prefix-XOR from the MSB down.
REQ-019 A single sub-module gray_encode (combinational, WIDTH-parameterised, wraps bin2gray) SHALL generate next gray.
REQ-020 The companion interface gray_counter_if SHALL:
- take clk as a port;
- carry rst, count (WIDTH) and gray (WIDTH);
- provide a driver clocking block that drives rst;
- provide a monitor clocking block that samples count and gray.

Verification
REQ-021 Bench SHALL use a 10 ns clk period and WIDTH=4, and SHALL cover:
- rst=0 for 3 edges -> o_o=0, gray=0 throughout; first edge after release -> o_o=1, gray=4'b0001.
- 16 edges free-running from 0 -> gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
- Wrap: o_o=15 (gray=1000) plus one edge -> o_o=0, gray=0000, exactly one bit changed.
- rst pulsed low mid-clock-period at o_o=9 -> outputs 0 before the next edge; the count resumes 1,2,3 after release.
- Scoreboard over 100+ cycles -> gray2bin(gray)==o_o and single-bit transition on every edge.
- Build with GRAY_COUNTER_ASSERT_EN -> zero assertion failures across all of the above.
